// File: rtl/ux607_uart0_pkg.sv
// Shared UART0 constants and types used by the receiver, transmitter and baud generator.
// Holds the FSM encoding, oversampling ratio, mid-bit vote ticks and data width.
package ux607_uart0_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int TICK_S0    = 7;
   localparam int TICK_S1    = 8;
   localparam int TICK_S2    = 9;
   localparam int DATA_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/ux607_uart0_rx_vote.sv
// rxd synchronizer plus a 3-sample majority voter.
// The first two mid-bit samples are stored; the third is the live synced value at the resolve tick.
module ux607_uart0_rx_vote
   import ux607_uart0_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic rxd,
   input  logic sample,
   output logic rxd_sync,
   output logic bit_val
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [1:0]             samp_q;

   // NOTE: the chain resets to 1 (line idle) so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         samp_q <= 2'b11;
      end else begin
         sync_q[0] <= rxd;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         if (sample) samp_q <= {samp_q[0], rxd_sync};
      end
   end

   assign rxd_sync = sync_q[SYNC_STAGES-1];
   assign bit_val  = maj3(samp_q[1], samp_q[0], rxd_sync);

endmodule

// File: rtl/ux607_uart0_rx.sv
// UART0 receiver: oversampled start/data/parity/stop FSM with a single-entry holding register.
// A completed byte overwrites an unaccepted one and pulses overrun.
module ux607_uart0_rx #(
   parameter int OVERSAMPLE  = ux607_uart0_pkg::OVERSAMPLE,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_data_sample,
   input  logic       rxd,
   input  logic       parity_en,
   input  logic       parity_odd,
   input  logic       data_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun
);

   import ux607_uart0_pkg::*;

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_W);
   typedef logic [CW-1:0] cnt_t;
   typedef logic [BW-1:0] idx_t;

   localparam cnt_t T_S0   = cnt_t'(TICK_S0);
   localparam cnt_t T_S1   = cnt_t'(TICK_S1);
   localparam cnt_t T_S2   = cnt_t'(TICK_S2);
   localparam cnt_t T_LAST = cnt_t'(OVERSAMPLE - 1);
   localparam idx_t I_LAST = idx_t'(DATA_W - 1);

   rx_state_e         state_q, state_d;
   cnt_t              cnt_q;
   idx_t              bit_idx_q;
   logic [DATA_W-1:0] shift_q;
   logic              par_en_q, par_odd_q, par_err_q;
   logic              rxd_sync, bit_val;
   logic              at_res, at_last, vote_sample, complete;

   assign at_res      = rx_data_sample && (cnt_q == T_S2);
   assign at_last     = rx_data_sample && (cnt_q == T_LAST);
   assign vote_sample = rx_data_sample && ((cnt_q == T_S0) || (cnt_q == T_S1));

   ux607_uart0_rx_vote #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_vote (
      .clk     (clk),
      .rst     (rst),
      .rxd     (rxd),
      .sample  (vote_sample),
      .rxd_sync(rxd_sync),
      .bit_val (bit_val)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      complete = 1'b0;
      unique case (state_q)
         ST_IDLE:   if (rx_data_sample && !rxd_sync) state_d = ST_START;
         ST_START: begin
            if (at_res && bit_val) state_d = ST_IDLE;
            else if (at_last)      state_d = ST_DATA;
         end
         ST_DATA:   if (at_last && bit_idx_q == I_LAST) state_d = par_en_q ? ST_PARITY : ST_STOP;
         ST_PARITY: if (at_last) state_d = ST_STOP;
         ST_STOP: begin
            if (at_res) begin
               state_d  = ST_IDLE;
               complete = 1'b1;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         par_err_q  <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (rx_data_sample)
            cnt_q <= (state_q == ST_IDLE || cnt_q == T_LAST) ? '0 : cnt_q + cnt_t'(1);

         // Frame options are frozen at the end of the start bit.
         if (state_q == ST_START && at_last) begin
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
            par_err_q <= 1'b0;
            bit_idx_q <= '0;
         end
         if (state_q == ST_DATA) begin
            if (at_res)  shift_q   <= {bit_val, shift_q[DATA_W-1:1]};
            if (at_last) bit_idx_q <= bit_idx_q + idx_t'(1);
         end
         if (state_q == ST_PARITY && at_res)
            par_err_q <= bit_val ^ (^shift_q) ^ par_odd_q;

         overrun <= complete && rx_valid && !data_ready;
         if (complete) begin
            rx_data    <= shift_q;
            parity_err <= par_err_q;
            frame_err  <= !bit_val;
            rx_valid   <= 1'b1;
         end else if (rx_valid && data_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
